digit_scan_ctrl: RTL and testbench
==================================

Name: digit_scan_ctrl

Overview:
- Time-multiplexing scheduler that shares one seven-segment decoder and one segment bus between N_DIGITS common-anode/cathode digits.
- Selects one nibble per dwell slot, drives the matching digit enable, and inserts a blanking gap between slots so segment data settles before the next digit lights (no ghosting).
- Captures the full digit word once per frame so a displayed frame never mixes old and new values.
- Sits between the switch/adder logic and the existing seven-segment decoder in the lab top level.

Parameters:
- N_DIGITS, 2, number of multiplexed digits; legal range >= 2.
- DWELL_CYCLES, 24000, clocks each digit is lit (1 ms at 24 MHz); must be >= 1.
- BLANK_CYCLES, 240, clocks all digits are off between slots (10 us at 24 MHz); must be >= 1.

Ports:
- clk  input  1  system clock (24 MHz HSOSC).
- reset  input  1  synchronous, active-low reset.
- digits_in  input  4*N_DIGITS  nibble k = digits_in[4k+3:4k] is shown on digit k.
- hex_out  output  4  nibble to the seven-segment decoder.
- digit_en  output  N_DIGITS  one-hot-or-zero digit enables, active-high; bit k lights digit k.
- cur_digit  output  max(1,$clog2(N_DIGITS))  index of the digit selected by hex_out.
- frame_tick  output  1  one-cycle pulse on the first lit cycle of digit 0.

Behaviour:
- All outputs registered; a single counter cnt plus a 2-state FSM {BLANK, ON}.
- Reset (reset==0 at a clk edge): state=BLANK, cnt=0, cur_digit=0, digit_en=0, hex_out=0, frame_tick=0, snapshot=0. Reset takes effect at that edge, including mid-ON.
- BLANK: digit_en=0. cnt increments each cycle.
  - While cur_digit==0: snapshot<=digits_in and hex_out<=digits_in[3:0] every cycle (tracking).
  - At cnt==BLANK_CYCLES-1: go to ON, cnt<=0, digit_en<=onehot(cur_digit). If cur_digit==0, snapshot freezes and frame_tick<=1 for exactly that cycle.
- ON: digit_en holds onehot(cur_digit). cnt increments each cycle.
  - At cnt==DWELL_CYCLES-1: go to BLANK, cnt<=0, digit_en<=0, cur_digit<=next, hex_out<=snapshot nibble[next].
  - next = cur_digit+1, wrapping from N_DIGITS-1 to 0.
- hex_out changes only on the ON->BLANK edge or during the BLANK-tracking phase; it never changes while any digit_en bit is high.
- Timing from the first cycle with reset high:
  - BLANK_CYCLES cycles dark.
  - digit 0 lit for DWELL_CYCLES cycles.
  - BLANK_CYCLES cycles dark.
  - digit 1 lit for DWELL_CYCLES cycles, and so on.
  - Frame period = N_DIGITS*(DWELL_CYCLES+BLANK_CYCLES).
- digits_in changes while any digit is lit affect only the next frame.
- Invariants: at most one digit_en bit high. At least BLANK_CYCLES zero cycles between any two lit slots. cnt width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1); cnt never exceeds its terminal value.

Optional Feature:
- Macro: DIGIT_SCAN_DIM_EN.
- Defined: adds input port duty (4 bits), captured into duty_q together with the snapshot freeze.
  - Within ON, digit_en = onehot(cur_digit) only while cnt*16 < DWELL_CYCLES*duty_q; otherwise 0.
  - duty 0 = dark. duty 15 = 15/16 on-time.
  - Slot timing, cur_digit, hex_out and frame_tick are unchanged.
- Not defined: no duty port; digit_en is high for the full dwell.

Test Plan (N_DIGITS=2, DWELL_CYCLES=4, BLANK_CYCLES=2 unless noted):
- reset low 3 cycles -> digit_en=00, hex_out=0, cur_digit=0, frame_tick=0 on every cycle.
- release reset, digits_in=8'h3A:
  - cycles 1-2: digit_en=00, hex_out=A.
  - cycles 3-6: digit_en=01, hex_out=A, frame_tick=1 on cycle 3 only.
  - cycles 7-8: digit_en=00, hex_out=3.
  - cycles 9-12: digit_en=10, hex_out=3.
  - cycle 13: dark again; repeats with period 12.
- digits_in changed to 8'h5C during digit 0 lit -> digit 1 slot still shows 3; next frame shows C on digit 0, then 5 on digit 1.
- 2000 random cycles, random digits_in -> assert digit_en onehot0, >= 2 zero cycles between lit slots, and hex_out stable whenever digit_en != 0.
- reset low for 1 cycle during digit 1 lit -> digit_en=00 at that edge; after release, sequence restarts with 2 dark cycles then digit 0.
- DIGIT_SCAN_DIM_EN, DWELL_CYCLES=16, duty=8 -> each slot lit exactly 8 of 16 cycles (first 8); duty=0 -> digit_en never high, frame_tick still pulses once per 36 cycles.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner: one nibble per dwell slot with a blanking gap
// between slots. Optional PWM dimming is enabled by defining DIGIT_SCAN_DIM_EN.
module digit_scan_ctrl #(
  parameter int N_DIGITS     = 2,
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 240,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
`ifdef DIGIT_SCAN_DIM_EN
  input  logic [3:0]            duty,
`endif
  output logic [3:0]            hex_out,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic [IW-1:0]         cur_digit,
  output logic                  frame_tick
);

  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic {BLANK, ON} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         cur_nxt, next_digit;
  logic [N_DIGITS-1:0]   en_nxt, onehot;
  logic [3:0]            hex_nxt;
  logic                  ft_nxt;
  logic [4*N_DIGITS-1:0] snap, snap_nxt;

`ifdef DIGIT_SCAN_DIM_EN
  logic [3:0] duty_q, duty_nxt;

  // Lit while cnt/DWELL < duty/16, evaluated without division.
  function automatic logic dim_on(input int c, input logic [3:0] d);
    return (c * 16) < (DWELL_CYCLES * int'(d));
  endfunction
`endif

  assign onehot     = {{(N_DIGITS-1){1'b0}}, 1'b1} << cur_digit;
  assign next_digit = (cur_digit == IDX_LAST) ? '0 : cur_digit + IDX_ONE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    cur_nxt   = cur_digit;
    en_nxt    = digit_en;
    hex_nxt   = hex_out;
    ft_nxt    = 1'b0;
    snap_nxt  = snap;
`ifdef DIGIT_SCAN_DIM_EN
    duty_nxt  = duty_q;
`endif
    case (state)
      BLANK: begin
        en_nxt = '0;
        // Before digit 0 lights the snapshot follows the input, so the frame
        // latches whatever is present on the last blank cycle.
        if (cur_digit == '0) begin
          snap_nxt = digits_in;
          hex_nxt  = digits_in[3:0];
        end
        if (cnt == BLANK_LAST) begin
          state_nxt = ON;
          cnt_nxt   = '0;
          ft_nxt    = (cur_digit == '0);
`ifdef DIGIT_SCAN_DIM_EN
          if (cur_digit == '0) duty_nxt = duty;
          en_nxt = dim_on(0, duty_nxt) ? onehot : '0;
`else
          en_nxt = onehot;
`endif
        end
      end
      ON: begin
`ifdef DIGIT_SCAN_DIM_EN
        en_nxt = dim_on(int'(cnt_nxt), duty_q) ? onehot : '0;
`else
        en_nxt = onehot;
`endif
        if (cnt == DWELL_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          en_nxt    = '0;
          cur_nxt   = next_digit;
          hex_nxt   = snap[4*int'(next_digit) +: 4];
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= BLANK;
      cnt        <= '0;
      cur_digit  <= '0;
      digit_en   <= '0;
      hex_out    <= '0;
      frame_tick <= 1'b0;
      snap       <= '0;
`ifdef DIGIT_SCAN_DIM_EN
      duty_q     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_digit  <= cur_nxt;
      digit_en   <= en_nxt;
      hex_out    <= hex_nxt;
      frame_tick <= ft_nxt;
      snap       <= snap_nxt;
`ifdef DIGIT_SCAN_DIM_EN
      duty_q     <= duty_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: position-in-frame reference model, directed
// sequence pins, random digit words and a mid-slot reset.
module tb_digit_scan_ctrl;
  localparam int N = 2;
  localparam int D = 4;
  localparam int B = 2;
  localparam int S = D + B;
  localparam int F = N * S;

  typedef logic [4*N-1:0] word_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  word_t        digits_in = '0;
`ifdef DIGIT_SCAN_DIM_EN
  logic [3:0]   duty = 4'd15;
`endif
  logic [3:0]   hex_out;
  logic [N-1:0] digit_en;
  logic [0:0]   cur_digit;
  logic         frame_tick;

  int tests = 0;
  int fails = 0;

  digit_scan_ctrl #(.N_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
`ifdef DIGIT_SCAN_DIM_EN
    .duty      (duty),
`endif
    .hex_out   (hex_out),
    .digit_en  (digit_en),
    .cur_digit (cur_digit),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: s counts clock edges since reset released; everything follows
  // from the position within the frame.
  int           s = 0;
  word_t        m_snap = '0;
  int           m_duty = 16;
  logic [3:0]   e_hex = '0;
  logic [N-1:0] e_en = '0;
  int           e_cd = 0;
  logic         e_ft = 1'b0;

  always @(posedge clk) begin
    int q, j, r;
    if (!reset) begin
      s      = 0;
      m_snap = '0;
    end else begin
      s++;
    end
    q = s % F;
    j = q / S;
    r = q % S;
    if (s > 0 && q == B) begin
      m_snap = digits_in;
`ifdef DIGIT_SCAN_DIM_EN
      m_duty = int'(duty);
`endif
    end
    e_cd = j;
    e_ft = (s > 0) && (q == B);
    e_en = (r >= B && (r - B) * 16 < D * m_duty) ? N'(1 << j) : '0;
    if (s == 0)               e_hex = 4'h0;
    else if (j == 0 && r < B) e_hex = (q == 0) ? m_snap[3:0] : digits_in[3:0];
    else                      e_hex = m_snap[4*j +: 4];
  end

  bit           chk_on = 1'b0;
  bit           seen_lit = 1'b0;
  int           zeros = 0;
  logic [N-1:0] prev_en = '0;
  logic [3:0]   prev_hex = '0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("digit_en", digit_en, e_en);
      chk("hex_out", hex_out, e_hex);
      chk("cur_digit", cur_digit, e_cd);
      chk("frame_tick", frame_tick, e_ft);
      chk("onehot0", ($countones(digit_en) <= 1), 1);
      if (digit_en != 0 && prev_en == 0 && seen_lit) chk("blank_gap", (zeros >= B), 1);
      if (digit_en != 0 && prev_en != 0) chk("hex_stable", hex_out, prev_hex);
      if (digit_en != 0) begin
        seen_lit = 1'b1;
        zeros    = 0;
      end else begin
        zeros++;
      end
      prev_en  = digit_en;
      prev_hex = hex_out;
    end
  end

  logic [1:0] en_t [24] = '{0,0,1,1,1,1,0,0,2,2,2,2,0,0,1,1,1,1,0,0,2,2,2,2};
  logic [3:0] hx_t [24] = '{0,4'hA,4'hA,4'hA,4'hA,4'hA,3,3,3,3,3,3,
                            4'hA,4'hC,4'hC,4'hC,4'hC,4'hC,5,5,5,5,5,5};

  initial begin
    int guard;
    chk_on    = 1'b1;
    reset     = 1'b0;
    digits_in = 8'h3A;
    repeat (3) begin
      @(negedge clk);
      chk("rst_en", digit_en, 0);
      chk("rst_hex", hex_out, 0);
      chk("rst_cd", cur_digit, 0);
      chk("rst_ft", frame_tick, 0);
    end
    reset = 1'b1;
    for (int i = 1; i < 24; i++) begin
      @(negedge clk);
      chk("seq_en", digit_en, en_t[i]);
      chk("seq_hex", hex_out, hx_t[i]);
      chk("seq_ft", frame_tick, (i == 2 || i == 14));
      if (i == 3) digits_in = 8'h5C;
    end

    repeat (2000) begin
      @(negedge clk);
      digits_in = word_t'($urandom);
`ifdef DIGIT_SCAN_DIM_EN
      duty = 4'($urandom);
`endif
    end

`ifdef DIGIT_SCAN_DIM_EN
    duty = 4'd15;
`endif
    guard = 0;
    while (digit_en != 2'b10 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("find_digit1", (guard < 100), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_en", digit_en, 0);
    chk("midrst_cd", cur_digit, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("restart_dark", digit_en, 0);
    @(negedge clk);
    chk("restart_d0", digit_en, 1);
    repeat (30) @(negedge clk);

`ifdef DIGIT_SCAN_DIM_EN
    duty = 4'd0;
    repeat (40) @(negedge clk);
    duty = 4'd8;
    repeat (40) @(negedge clk);
`endif

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
